// File: rtl/aes_key_schedule.sv
// aes_key_schedule: iterative AES-128/192/256 key expansion, one word per clock, indexed round-key read (AES_KS_STREAM_EN adds a per-round stream port)
module aes_key_schedule #(
  parameter int KEY_BITS = 128,
  parameter int IDX_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                done,
  output logic                key_valid,
  input  logic [IDX_W-1:0]    rk_idx,
  output logic [127:0]        round_key
`ifdef AES_KS_STREAM_EN
  ,
  output logic                rk_stream_valid,
  output logic [IDX_W-1:0]    rk_stream_idx,
  output logic [127:0]        rk_stream_key
`endif
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam int CW = $clog2(NW);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  typedef enum logic {IDLE, GEN} state_t;
  state_t state;
  logic [31:0] w [NW];
  logic [CW-1:0] i, rb;
  logic [2:0] j;
  logic [7:0] rcon;
  logic [31:0] prev, sub_in, sub, temp, new_w;
  always_comb begin
    prev = w[i - CW'(1)];
    sub_in = (j == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    sub = {SBOX[sub_in[31:24]], SBOX[sub_in[23:16]], SBOX[sub_in[15:8]], SBOX[sub_in[7:0]]};
    temp = (j == 3'd0) ? sub ^ {rcon, 24'h0} : (NK == 8 && j == 3'd4) ? sub : prev;
    new_w = w[i - CW'(NK)] ^ temp;
    rb = CW'({rk_idx, 2'b00});
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      key_valid <= 1'b0;
      round_key <= '0;
      i <= '0;
      j <= '0;
      rcon <= 8'h01;
    end else begin
      done <= 1'b0;
      round_key <= (key_valid && rk_idx <= IDX_W'(NR)) ?
                   {w[rb], w[rb + CW'(1)], w[rb + CW'(2)], w[rb + CW'(3)]} : '0;
      if (state == IDLE) begin
        if (start) begin
          for (int k = 0; k < NK; k++) w[CW'(k)] <= key_in[KEY_BITS-1-32*k -: 32];
          i <= CW'(NK);
          j <= '0;
          rcon <= 8'h01;
          busy <= 1'b1;
          key_valid <= 1'b0;
          state <= GEN;
        end
      end else begin
        w[i] <= new_w;
        i <= i + CW'(1);
        j <= (j == 3'(NK - 1)) ? 3'd0 : j + 3'd1;
        if (j == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        if (i == CW'(NW - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
          key_valid <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
`ifdef AES_KS_STREAM_EN
  logic s_on, ready;
  logic [IDX_W-1:0] sr;
  logic [CW-1:0] sb, sl;
  always_comb begin
    sb = CW'({sr, 2'b00});
    sl = sb + CW'(3);
    ready = state == GEN && sl <= i;
  end
  // The last word of a round is forwarded from the word being written this edge
  always_ff @(posedge clk) begin
    if (reset) begin
      s_on <= 1'b0;
      sr <= '0;
      rk_stream_valid <= 1'b0;
      rk_stream_idx <= '0;
      rk_stream_key <= '0;
    end else begin
      rk_stream_valid <= 1'b0;
      if (state == IDLE && start) begin
        rk_stream_valid <= 1'b1;
        rk_stream_idx <= '0;
        rk_stream_key <= key_in[KEY_BITS-1 -: 128];
        sr <= IDX_W'(1);
        s_on <= 1'b1;
      end else if (s_on && ready) begin
        rk_stream_valid <= 1'b1;
        rk_stream_idx <= sr;
        rk_stream_key <= {w[sb], w[sb + CW'(1)], w[sb + CW'(2)], (sl == i) ? new_w : w[sl]};
        sr <= sr + IDX_W'(1);
        s_on <= sr != IDX_W'(NR);
      end
    end
  end
`endif
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: directed FIPS-197 vectors on 128/192/256-bit instances
module tb_aes_key_schedule;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;
  logic s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;
  logic [127:0] k0 = '0;
  logic [191:0] k1 = '0;
  logic [255:0] k2 = '0;
  logic [3:0] r0 = '0, r1 = '0, r2 = '0;
  logic b0, b1, b2, d0, d1, d2, v0, v1, v2;
  logic [127:0] q0, q1, q2;
  int pass = 0, total = 0;
  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`ifdef AES_KS_STREAM_EN
  logic sv0, sv1, sv2;
  logic [3:0] si0, si1, si2;
  logic [127:0] sk0, sk1, sk2;
`endif
  aes_key_schedule #(.KEY_BITS(128)) u128 (
    .clk(clk), .reset(reset), .start(s0), .key_in(k0), .busy(b0), .done(d0),
    .key_valid(v0), .rk_idx(r0), .round_key(q0)
`ifdef AES_KS_STREAM_EN
    , .rk_stream_valid(sv0), .rk_stream_idx(si0), .rk_stream_key(sk0)
`endif
  );
  aes_key_schedule #(.KEY_BITS(192)) u192 (
    .clk(clk), .reset(reset), .start(s1), .key_in(k1), .busy(b1), .done(d1),
    .key_valid(v1), .rk_idx(r1), .round_key(q1)
`ifdef AES_KS_STREAM_EN
    , .rk_stream_valid(sv1), .rk_stream_idx(si1), .rk_stream_key(sk1)
`endif
  );
  aes_key_schedule #(.KEY_BITS(256)) u256 (
    .clk(clk), .reset(reset), .start(s2), .key_in(k2), .busy(b2), .done(d2),
    .key_valid(v2), .rk_idx(r2), .round_key(q2)
`ifdef AES_KS_STREAM_EN
    , .rk_stream_valid(sv2), .rk_stream_idx(si2), .rk_stream_key(sk2)
`endif
  );
  function automatic logic dn(input int u);
    return (u == 0) ? d0 : (u == 1) ? d1 : d2;
  endfunction
  task automatic go(input int u, output int n);
    @(negedge clk);
    if (u == 0) s0 = 1'b1; else if (u == 1) s1 = 1'b1; else s2 = 1'b1;
    @(posedge clk);
    #1;
    s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
    n = 0;
    while (!dn(u) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask
  task automatic rd(input int u, input logic [3:0] idx, output logic [127:0] q);
    @(negedge clk);
    if (u == 0) r0 = idx; else if (u == 1) r1 = idx; else r2 = idx;
    @(posedge clk);
    #1;
    q = (u == 0) ? q0 : (u == 1) ? q1 : q2;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({b0, d0, v0, b1, d1, v1, b2, d2, v2} !== 9'b0)
      $display("FAIL reset_flags: got %b want 0", {b0, d0, v0, b1, d1, v1, b2, d2, v2});
    else pass++;
    total++;
    if ({q0, q1, q2} !== '0) $display("FAIL reset_round_key: got %h want 0", q0);
    else pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_128;
    int n;
    logic [127:0] q;
    k0 = K128;
    go(0, n);
    total++;
    if (n !== 40) $display("FAIL k128_latency: got %0d want 40", n); else pass++;
    total++;
    if (v0 !== 1'b1) $display("FAIL k128_key_valid: got %b want 1", v0); else pass++;
    rd(0, 4'd1, q);
    total++;
    if (q !== RK1) $display("FAIL k128_rk1: got %h want %h", q, RK1); else pass++;
    rd(0, 4'd10, q);
    total++;
    if (q !== RK10) $display("FAIL k128_rk10: got %h want %h", q, RK10); else pass++;
    rd(0, 4'd0, q);
    total++;
    if (q !== K128) $display("FAIL k128_rk0: got %h want %h", q, K128); else pass++;
    rd(0, 4'd11, q);
    total++;
    if (q !== '0) $display("FAIL k128_rk11: got %h want 0", q); else pass++;
  endtask
  task automatic test_192;
    int n;
    logic [127:0] q;
    k1 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    go(1, n);
    total++;
    if (n !== 46) $display("FAIL k192_latency: got %0d want 46", n); else pass++;
    rd(1, 4'd12, q);
    total++;
    if (q !== 128'he98ba06f448c773c8ecc720401002202)
      $display("FAIL k192_rk12: got %h want e98ba06f448c773c8ecc720401002202", q);
    else pass++;
    rd(1, 4'd13, q);
    total++;
    if (q !== '0) $display("FAIL k192_rk13: got %h want 0", q); else pass++;
  endtask
  task automatic test_256;
    int n;
    logic [127:0] q;
    k2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    go(2, n);
    total++;
    if (n !== 52) $display("FAIL k256_latency: got %0d want 52", n); else pass++;
    rd(2, 4'd14, q);
    total++;
    if (q !== 128'hfe4890d1e6188d0b046df344706c631e)
      $display("FAIL k256_rk14: got %h want fe4890d1e6188d0b046df344706c631e", q);
    else pass++;
    rd(2, 4'd1, q);
    total++;
    if (q !== 128'h1f352c073b6108d72d9810a30914dff4)
      $display("FAIL k256_rk1: got %h want 1f352c073b6108d72d9810a30914dff4", q);
    else pass++;
  endtask
  task automatic test_back_to_back;
    int n;
    logic [127:0] q;
    k0 = K128;
    @(negedge clk);
    s0 = 1'b1;
    @(posedge clk);
    #1;
    s0 = 1'b0;
    n = 0;
    while (!d0 && n < 200) begin
      s0 = (n == 10);
      if (n == 10) k0 = 128'h000102030405060708090a0b0c0d0e0f;
      total++;
      if (n > 0 && q0 !== '0) $display("FAIL busy_round_key: got %h want 0", q0); else pass++;
      @(posedge clk);
      #1;
      n++;
    end
    s0 = 1'b0;
    total++;
    if (n !== 40) $display("FAIL ignore_restart_latency: got %0d want 40", n); else pass++;
    rd(0, 4'd10, q);
    total++;
    if (q !== RK10) $display("FAIL ignore_restart_rk10: got %h want %h", q, RK10); else pass++;
    rd(0, 4'd11, q);
    total++;
    if (q !== '0) $display("FAIL ignore_restart_rk11: got %h want 0", q); else pass++;
  endtask
  task automatic test_done_restart;
    int n;
    logic [127:0] q;
    k0 = K128;
    go(0, n);
    s0 = 1'b1;
    @(posedge clk);
    #1;
    s0 = 1'b0;
    total++;
    if ({b0, v0} !== 2'b10) $display("FAIL done_restart_flags: got %b want 10", {b0, v0}); else pass++;
    n = 0;
    while (!d0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n !== 40) $display("FAIL done_restart_latency: got %0d want 40", n); else pass++;
    rd(0, 4'd1, q);
    total++;
    if (q !== RK1) $display("FAIL done_restart_rk1: got %h want %h", q, RK1); else pass++;
  endtask
  task automatic test_reset_mid;
    int n;
    logic [127:0] q;
    k0 = K128;
    @(negedge clk);
    s0 = 1'b1;
    @(posedge clk);
    #1;
    s0 = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({b0, d0, v0} !== 3'b0) $display("FAIL mid_reset_flags: got %b want 000", {b0, d0, v0}); else pass++;
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r <= 10; r += 5) begin
      rd(0, 4'(r), q);
      total++;
      if (q !== '0) $display("FAIL mid_reset_rk%0d: got %h want 0", r, q); else pass++;
    end
    total++;
    if (d0 !== 1'b0) $display("FAIL mid_reset_no_done: got %b want 0", d0); else pass++;
    go(0, n);
    total++;
    if (n !== 40) $display("FAIL post_reset_latency: got %0d want 40", n); else pass++;
    rd(0, 4'd10, q);
    total++;
    if (q !== RK10) $display("FAIL post_reset_rk10: got %h want %h", q, RK10); else pass++;
  endtask
`ifdef AES_KS_STREAM_EN
  task automatic test_stream;
    int cnt, last, dcyc;
    logic [127:0] key10;
    k0 = K128;
    cnt = 0; last = -1; dcyc = -1; key10 = '0;
    @(negedge clk);
    s0 = 1'b1;
    @(posedge clk);
    #1;
    s0 = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (sv0) begin
        total++;
        if (si0 !== 4'(cnt)) $display("FAIL stream_idx: got %0d want %0d", si0, cnt); else pass++;
        if (si0 == 4'd10) key10 = sk0;
        cnt++;
        last = n;
      end
      if (d0) dcyc = n;
      @(posedge clk);
      #1;
    end
    total++;
    if (cnt !== 11) $display("FAIL stream_count: got %0d want 11", cnt); else pass++;
    total++;
    if (key10 !== RK10) $display("FAIL stream_key10: got %h want %h", key10, RK10); else pass++;
    total++;
    if (dcyc < 0 || last > dcyc) $display("FAIL stream_last_vs_done: got %0d want <= %0d", last, dcyc);
    else pass++;
  endtask
`endif
  initial begin
    test_reset;
    test_128;
    test_192;
    test_256;
    test_back_to_back;
    test_done_restart;
    test_reset_mid;
`ifdef AES_KS_STREAM_EN
    test_stream;
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- Parametrised, iterative AES key expansion engine. Supports 128-, 192- and 256-bit cipher keys.
- Generates one 32-bit schedule word per clock into an internal word store.
- Serves any round key through a registered, indexed read port.
- Sits between the key-input register and the round datapath. Replaces the fixed two-round-key expander of the 128-bit design.

Parameters:
- KEY_BITS, 128, cipher key width; legal values 128/192/256. Derived: Nk=KEY_BITS/32, Nr=Nk+6, NW=4*(Nr+1) (44/52/60).
- IDX_W, 4, width of round-key index.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request expansion of key_in; sampled only when idle
- key_in  in  KEY_BITS  cipher key, MSB-first (key_in[KEY_BITS-1 -: 32] = w[0])
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse, expansion complete
- key_valid  out  1  word store holds a complete schedule
- rk_idx  in  IDX_W  round number to read, 0..Nr
- round_key  out  128  {w[4r],w[4r+1],w[4r+2],w[4r+3]} for r=rk_idx; registered

Behaviour:
- Reset values: busy=0, done=0, key_valid=0, round_key=0, word counter=0, rcon=8'h01. Word store contents are not cleared.
- Idle states:
  - IDLE: wait for start=1.
  - At that edge (E0): write w[0..Nk-1] from key_in in parallel, set i=Nk, rcon=01, busy=1, key_valid=0. Go to GEN.
- GEN state, one word per edge, with temp=w[i-1]:
  - If i mod Nk==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon = xtime(rcon). Sequence 01,02,04,08,10,20,40,80,1B,36.
  - Else if Nk==8 and i mod Nk==4: temp = SubWord(temp).
  - Write w[i] = w[i-Nk] ^ temp, then i++.
- Completion: on the edge writing w[NW-1], busy<=0, done<=1, key_valid<=1, return to IDLE. done clears on the next edge.
- Latency from start edge E0 to done high: NW-Nk clocks (40/46/52).
- SubWord uses 4 combinational S-box instances. S-box is the FIPS-197 forward table.
- Read port:
  - round_key <= store[rk_idx] on every edge; 1-cycle latency from rk_idx.
  - If rk_idx>Nr or key_valid=0: round_key <= 0.
- Boundary conditions:
  - start while busy: ignored, no restart, no error.
  - start in the same cycle done=1: accepted (state is IDLE). key_valid drops next edge.
  - reset mid-GEN: returns to IDLE, busy/done/key_valid=0. The partial schedule is never exposed.
  - key_in is sampled only at E0. Later changes have no effect.
  - rk_idx change during busy: round_key stays 0.

Optional Feature:
- Macro: AES_KS_STREAM_EN.
- When defined, adds three outputs:
  - rk_stream_valid (1)
  - rk_stream_idx (IDX_W)
  - rk_stream_key (128)
- The stream outputs pulse for one cycle, registered, in the cycle after w[4r+3] becomes written, for each r=0..Nr in ascending order.
- The round datapath can therefore start before done.
- Round 0 streams at E0+1 for 128-bit keys. For Nk>4, early rounds stream as soon as their words are loaded, one per cycle in order.
- Stream outputs reset to 0. Exactly Nr+1 pulses per expansion. A reset mid-expansion stops the stream.
- When the macro is undefined, the ports and logic are absent. All other behaviour is identical.

Test Plan:
1. KEY_BITS=128, key_in=2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle:
   - done exactly 40 clocks after start edge.
   - rk_idx=1 -> a0fafe1788542cb123a339392a6c7605.
   - rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
   - rk_idx=0 -> key_in.
2. KEY_BITS=192, key_in=8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
   - done after 46 clocks.
   - rk_idx=12 -> e98ba06f448c773c8ecc720401002202.
3. KEY_BITS=256, key_in=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
   - done after 52 clocks.
   - rk_idx=14 -> fe4890d1e6188d0b046df344706c631e.
   - Exercises the i mod 8==4 SubWord path.
4. 128-bit run, second start at cycle 10 with a different key_in -> ignored. Done still at 40, results match scenario 1. rk_idx=11 -> round_key=0.
5. Assert reset for 1 cycle at cycle 20 of a 128-bit run -> busy/done/key_valid=0 next edge, round_key=0 for all idx. A fresh start then completes correctly in 40 clocks.
6. With AES_KS_STREAM_EN, 128-bit vector -> 11 rk_stream_valid pulses with idx 0..10 ascending. Key for idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6. The last pulse is no later than done.
